// File: rtl/up_counter_sync_if.sv
// up_counter_sync_if: control inputs and count/status outputs of the up counter.
interface up_counter_sync_if #(parameter int WIDTH = 4);
    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;
    logic             busy;
    modport master(output en, clr, load, load_val, max_val, input out, tc, ovf, busy);
    modport slave(input en, clr, load, load_val, max_val, output out, tc, ovf, busy);
endinterface

// File: rtl/up_counter_sync.sv
// up_counter_sync: synchronous modulus up counter with clear/load, terminal pulse,
// sticky overflow and optional one-shot stop at the terminal value.
module up_counter_sync #(
    parameter int WIDTH   = 4,
    parameter bit ONESHOT = 1'b0
) (
    input logic clk,
    input logic reset,
    up_counter_sync_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic at_max, near_max;
    always_comb begin
        at_max   = bus.out >= bus.max_val;
        near_max = WIDTH'(bus.out + 1'b1) == bus.max_val;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bus.out  <= '0;
            bus.tc   <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            bus.tc <= 1'b0;
            if (bus.clr) begin
                state    <= IDLE;
                bus.out  <= '0;
                bus.ovf  <= 1'b0;
                bus.busy <= 1'b0;
            end else if (bus.load) begin
                state    <= IDLE;
                bus.out  <= bus.load_val;
                bus.ovf  <= 1'b0;
                bus.busy <= 1'b0;
            end else if (state == DONE) begin
                bus.busy <= 1'b0;
            end else if (!bus.en) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else if (ONESHOT && (at_max || near_max)) begin
                // an out-of-range count stops where it is rather than snapping to max_val
                if (!at_max) bus.out <= bus.max_val;
                bus.tc   <= 1'b1;
                state    <= DONE;
                bus.busy <= 1'b0;
            end else if (at_max) begin
                bus.out  <= '0;
                bus.tc   <= 1'b1;
                bus.ovf  <= 1'b1;
                state    <= RUN;
                bus.busy <= 1'b1;
            end else begin
                bus.out  <= bus.out + 1'b1;
                state    <= RUN;
                bus.busy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_up_counter_sync.sv
// tb_up_counter_sync: directed checks of a free-running and a one-shot counter fed identical inputs.
module tb_up_counter_sync;
    logic clk = 1'b0;
    logic reset;
    logic en, clr, load;
    logic [3:0] load_val, max_val;
    int passed = 0;
    int total = 0;

    up_counter_sync_if #(.WIDTH(4)) ia ();
    up_counter_sync_if #(.WIDTH(4)) ib ();

    assign ia.en = en;
    assign ia.clr = clr;
    assign ia.load = load;
    assign ia.load_val = load_val;
    assign ia.max_val = max_val;
    assign ib.en = en;
    assign ib.clr = clr;
    assign ib.load = load;
    assign ib.load_val = load_val;
    assign ib.max_val = max_val;

    up_counter_sync #(.WIDTH(4), .ONESHOT(1'b0)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    up_counter_sync #(.WIDTH(4), .ONESHOT(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0; max_val = 4'd15;
        #3;
        chk("rst_out", 32'(ia.out), 0);
        chk("rst_tc", 32'(ia.tc), 0);
        chk("rst_ovf", 32'(ia.ovf), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_out_b", 32'(ib.out), 0);
        step();
        reset = 1'b0;
        // free run, max 15
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("free_out", 32'(ia.out), (i == 15) ? 0 : (i < 15 ? i + 1 : i - 15));
            chk("free_tc", 32'(ia.tc), (i == 15) ? 1 : 0);
            chk("free_ovf", 32'(ia.ovf), (i >= 15) ? 1 : 0);
            chk("free_busy", 32'(ia.busy), 1);
            chk("os15_out", 32'(ib.out), (i < 15) ? i + 1 : 15);
            chk("os15_tc", 32'(ib.tc), (i == 14) ? 1 : 0);
        end
        en = 1'b0;
        step();
        chk("hold_out", 32'(ia.out), 4);
        chk("hold_tc", 32'(ia.tc), 0);
        chk("hold_busy", 32'(ia.busy), 0);
        chk("hold_ovf", 32'(ia.ovf), 1);
        clr = 1'b1;
        step();
        chk("clr_out", 32'(ia.out), 0);
        chk("clr_ovf", 32'(ia.ovf), 0);
        chk("clr_out_b", 32'(ib.out), 0);
        // modulus 10
        clr = 1'b0; max_val = 4'd9; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("mod_out", 32'(ia.out), (i == 9) ? 0 : (i < 9 ? i + 1 : i - 9));
            chk("mod_tc", 32'(ia.tc), (i == 9) ? 1 : 0);
        end
        en = 1'b0; clr = 1'b1;
        step();
        // one-shot, max 5
        clr = 1'b0; max_val = 4'd5; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("os_out", 32'(ib.out), (i < 5) ? i + 1 : 5);
            chk("os_tc", 32'(ib.tc), (i == 4) ? 1 : 0);
            chk("os_busy", 32'(ib.busy), (i < 4) ? 1 : 0);
            chk("os_ovf", 32'(ib.ovf), 0);
        end
        chk("pre_load_ovf", 32'(ia.ovf), 1);
        // priority: load beats en, clr beats load
        load_val = 4'd12; load = 1'b1;
        step();
        chk("load_out", 32'(ia.out), 12);
        chk("load_ovf", 32'(ia.ovf), 0);
        chk("load_out_b", 32'(ib.out), 12);
        chk("load_busy_b", 32'(ib.busy), 0);
        clr = 1'b1;
        step();
        chk("clrload_out", 32'(ia.out), 0);
        chk("clrload_ovf", 32'(ia.ovf), 0);
        // asynchronous reset between edges
        clr = 1'b0; load = 1'b0; max_val = 4'd15;
        for (int i = 0; i < 7; i++) step();
        chk("pre_rst_out", 32'(ia.out), 7);
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_out", 32'(ia.out), 0);
        chk("arst_busy", 32'(ia.busy), 0);
        #1 reset = 1'b0; en = 1'b1;
        step();
        chk("post_rst_out", 32'(ia.out), 1);
        // boundary: max 0, then out-of-range load
        max_val = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("max0_out", 32'(ia.out), 0);
            chk("max0_tc", 32'(ia.tc), 1);
        end
        load_val = 4'd14; max_val = 4'd3; load = 1'b1;
        step();
        chk("oor_load_out", 32'(ia.out), 14);
        chk("oor_load_tc", 32'(ia.tc), 0);
        load = 1'b0;
        step();
        chk("oor_wrap_out", 32'(ia.out), 0);
        chk("oor_wrap_tc", 32'(ia.tc), 1);
        chk("oor_wrap_ovf", 32'(ia.ovf), 1);
        chk("oor_os_out", 32'(ib.out), 14);
        chk("oor_os_tc", 32'(ib.tc), 1);
        step();
        chk("oor_next_out", 32'(ia.out), 1);
        chk("oor_done_out", 32'(ib.out), 14);
        chk("oor_done_tc", 32'(ib.tc), 0);
        chk("oor_done_busy", 32'(ib.busy), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/up_counter_sync.md
UP_COUNTER_SYNC -- requirements
Module: up_counter_sync

Interface
REQ-001 The block SHALL have the parameter WIDTH, default 4, which sets the counter width in bits.
REQ-002 The block SHALL have the parameter ONESHOT, default 0; 0 means free-running wrap and 1 means stop at the terminal value.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, WIDTH bits: the value taken on load.
REQ-009 The block SHALL have port max_val, input, WIDTH bits: the terminal (modulus-1) value, sampled every cycle.
REQ-010 The block SHALL have port out, output, WIDTH bits: the current count, registered.
REQ-011 The block SHALL have port tc, output, 1 bit: a registered one-cycle pulse on each wrap or terminal arrival.
REQ-012 The block SHALL have port ovf, output, 1 bit: a sticky flag, set on any wrap and cleared by clr, load or reset.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN.

Function
REQ-014 The counter SHALL be fully synchronous: all bits of out SHALL change on the same clk edge, with no derived clocks and no ripple.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE; DONE SHALL be reachable only when ONESHOT=1.
REQ-016 Per-cycle priority SHALL be: reset > clr > load > count > hold.
REQ-017 On clr=1, the block SHALL set out to 0, tc to 0, ovf to 0 and the state to IDLE on the next edge.
REQ-018 On load=1 with clr=0, the block SHALL set out to load_val, tc to 0, ovf to 0 and the state to IDLE; en in the same cycle SHALL be ignored.
REQ-019 In IDLE or RUN with en=1 and out < max_val, the block SHALL set out to out+1 and the state to RUN.
REQ-020 With en=1 and out >= max_val and ONESHOT=0, the block SHALL set out to 0, pulse tc to 1 for exactly one cycle, set ovf to 1 and keep the state RUN.
REQ-021 With en=1 and out+1 == max_val and ONESHOT=1, the block SHALL set out to max_val, pulse tc to 1 for one cycle, and set the state to DONE.
REQ-022 With en=1 and out >= max_val already and ONESHOT=1, the block SHALL go directly to DONE with out unchanged and tc pulsed once.
REQ-023 In DONE, the block SHALL hold out and ignore en; it SHALL leave DONE only via clr, load or reset.
REQ-024 With en=0 in RUN, the block SHALL hold out and tc=0, and the state SHALL return to IDLE.
REQ-025 When max_val=0 and ONESHOT=0 with en held at 1, out SHALL stay 0 and tc SHALL pulse every cycle.
REQ-026 When load_val > max_val is loaded, the next enabled cycle SHALL wrap per REQ-020 and REQ-022; it SHALL NOT count past max_val.
REQ-027 If max_val changes mid-count, the new value SHALL be compared on the very next enabled edge.
REQ-028 At WIDTH=4 with max_val=15, the sequence SHALL be 0..15 and then 0; arithmetic SHALL be modulo 2^WIDTH with no carry-out port.
REQ-029 Latency SHALL be one clk cycle from an en/clr/load sample to the out/tc update.

Reset
REQ-030 When reset=1, the block SHALL immediately, without waiting for clk, force out=0, tc=0, ovf=0, busy=0 and state=IDLE.
REQ-031 Reset asserted mid-count SHALL abort the count; after deassertion the first enabled edge SHALL produce out=1.
REQ-032 Reset deassertion SHALL be synchronised externally; the block SHALL need no reset sequencing beyond reset=1 for at least one clk edge.

Verification
REQ-033 Free-run scenario: WIDTH=4, max_val=15, en=1 for 20 cycles -> out goes 1..15, 0, 1..4; tc is high only on the cycle out=0; ovf=1 from then on.
REQ-034 Modulus scenario: max_val=9, en=1 for 12 cycles -> out goes 1..9, 0, 1, 2; tc pulses once, when out returns to 0.
REQ-035 One-shot scenario: ONESHOT=1, max_val=5, en=1 for 8 cycles -> out goes 1..5 and stays at 5; tc pulses once, when out=5; busy=0 in DONE.
REQ-036 Priority scenario: load_val=12 with load=1, en=1 and clr=0 -> out=12; next cycle with clr=1 and load=1 -> out=0 and ovf=0.
REQ-037 Asynchronous reset scenario: reset pulsed between edges while out=7 -> out=0 before the next edge; a following en -> out=1.
REQ-038 Boundary scenario: max_val=0, en=1 -> out=0 and tc=1 on every cycle; then load_val=14 with max_val=3 -> the next enabled edge gives out=0 and tc=1.
